// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle between a requester and the bit-serial adder.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic cin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic sum_bit;
  modport master(output start, a_in, b_in, cin, input busy, done, sum, cout, sum_bit);
  modport slave(input start, a_in, b_in, cin, output busy, done, sum, cout, sum_bit);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: one full_adder reused over WIDTH clocks, LSB first, carry held in a flop.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic Sum,
  output logic Carry
);
  assign Sum = a ^ b ^ c;
  assign Carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] sa, sb, acc, acc_nxt;
  logic [CW-1:0] cnt;
  logic carry_q, s, co, accept, last;
  full_adder fa (.a(sa[0]), .b(sb[0]), .c(carry_q), .Sum(s), .Carry(co));
  assign accept = bus.start && state != S_SHIFT;
  assign last = cnt == CW'(WIDTH - 1);
  // shift form keeps WIDTH=1 legal where a part-select would reverse
  assign acc_nxt = (acc >> 1) | (WIDTH'(s) << (WIDTH - 1));
  assign bus.busy = state == S_SHIFT;
  assign bus.done = state == S_DONE;
  assign bus.sum_bit = bus.busy & s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sa <= '0;
      sb <= '0;
      acc <= '0;
      cnt <= '0;
      carry_q <= 1'b0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
    end else if (accept) begin
      sa <= bus.a_in;
      sb <= bus.b_in;
      carry_q <= bus.cin;
      cnt <= '0;
      acc <= '0;
      state <= S_SHIFT;
    end else if (state == S_SHIFT) begin
      carry_q <= co;
      acc <= acc_nxt;
      sa <= sa >> 1;
      sb <= sb >> 1;
      cnt <= cnt + 1'b1;
      if (last) begin
        bus.sum <= acc_nxt;
        bus.cout <= co;
        state <= S_DONE;
      end
    end else begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors plus a cycle-level arithmetic model of the 8-bit adder; exhaustive 2-bit sweep.
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 0, rst_n = 0;
  int checks = 0, errors = 0;
  serial_adder_if #(W) b8 ();
  serial_adder_if #(2) b2 ();
  serial_adder #(.WIDTH(W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  // model: an op accepted at edge index ops is busy for W cycles, then done; result is a+b+cin
  int cyc = 0, ops = -100;
  logic [W:0] pend = '0, last = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      ops <= -100;
      last <= '0;
    end else begin
      cyc <= cyc + 1;
      if (cyc - ops == W - 1) last <= pend;
      if (b8.start && !(cyc - ops >= 0 && cyc - ops <= W - 1)) begin
        ops <= cyc + 1;
        pend <= b8.a_in + b8.b_in + b8.cin;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int p;
    logic eb;
    logic [11:0] e;
    p = cyc - ops;
    eb = p >= 0 && p <= W - 1;
    e = '0;
    if (rst_n) begin
      e = {eb, p == W, last[W], last[W-1:0], 1'b0};
      if (eb) e[0] = pend[p];
    end
    chk("cycle{busy,done,cout,sum,sum_bit}", {b8.busy, b8.done, b8.cout, b8.sum, b8.sum_bit}, e);
  end

  logic [7:0] seq;
  int nb, n;
  logic [2:0] d;

  task automatic wait_done();
    for (int i = 0; i < 30 && !b8.done; i++) @(negedge clk);
    chk("done_seen", b8.done, 1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    b8.a_in = a; b8.b_in = b; b8.cin = c; b8.start = 1;
    @(negedge clk);
    b8.start = 0;
    nb = 0;
    seq = '0;
    for (int i = 0; i < 30 && !b8.done; i++) begin
      if (b8.busy && nb < 8) seq[nb] = b8.sum_bit;
      if (b8.busy) nb++;
      @(negedge clk);
    end
    chk("done_seen", b8.done, 1);
  endtask

  initial begin
    b8.start = 0; b8.a_in = 0; b8.b_in = 0; b8.cin = 0;
    b2.start = 0; b2.a_in = 0; b2.b_in = 0; b2.cin = 0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {b8.busy, b8.done, b8.cout, b8.sum, b8.sum_bit}, 0);
    #2 rst_n = 1;
    @(negedge clk);
    op8(8'h3C, 8'h42, 0);
    chk("basic_sum", b8.sum, 8'h7E);
    chk("basic_cout", b8.cout, 0);
    chk("basic_busy_cycles", nb, 8);
    chk("basic_sum_bits", seq, 8'h7E);
    op8(8'hFF, 8'h01, 0);
    chk("ripple1", {b8.cout, b8.sum}, 9'h100);
    op8(8'h5A, 8'hA5, 1);
    chk("ripple2", {b8.cout, b8.sum}, 9'h100);
    repeat (3) @(negedge clk);
    b8.a_in = 8'h20; b8.b_in = 8'h03; b8.cin = 0; b8.start = 1;
    @(negedge clk); b8.start = 0;
    @(negedge clk);
    b8.a_in = 8'h11; b8.start = 1;
    @(negedge clk); b8.start = 0;
    wait_done();
    chk("ignore_start", {b8.cout, b8.sum}, 9'h023);
    repeat (12) @(negedge clk);
    b8.a_in = 8'h01; b8.b_in = 8'h01; b8.cin = 0; b8.start = 1;
    wait_done();
    chk("b2b_first", {b8.cout, b8.sum}, 9'h002);
    b8.a_in = 8'h80; b8.b_in = 8'h80;
    @(negedge clk); b8.start = 0;
    n = 1;
    while (!b8.done && n < 30) begin @(negedge clk); n++; end
    chk("b2b_gap", n, 9);
    chk("b2b_second", {b8.cout, b8.sum}, 9'h100);
    repeat (2) @(negedge clk);
    b8.a_in = 8'h33; b8.b_in = 8'h44; b8.start = 1;
    @(negedge clk); b8.start = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("rst_midop", {b8.busy, b8.done, b8.cout, b8.sum, b8.sum_bit}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      b2.a_in = i[1:0]; b2.b_in = i[3:2]; b2.cin = i[4]; b2.start = 1;
      @(negedge clk); b2.start = 0;
      d[2] = b2.done;
      @(negedge clk); d[1] = b2.done;
      @(negedge clk); d[0] = b2.done;
      chk("w2_done_timing", d, 3'b001);
      chk("w2_sum", {b2.cout, b2.sum}, i[1:0] + i[3:2] + i[4]);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder built around the one-bit full_adder cell (ports a, b, c, Sum, Carry). The block captures two WIDTH-bit operands and a carry-in. It feeds one operand bit pair per clock, LSB first, into a single full_adder instance, and keeps the carry in a flip-flop between bits. It collects the serial sum bits into a parallel result, flags completion, and trades adder area for WIDTH cycles of latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset; reset is asserted asynchronously and released synchronously to clk by the system.
start  input  1  request to begin an addition; sampled on rising clk.
a_in  input  WIDTH  operand A; captured when start is accepted.
b_in  input  WIDTH  operand B; captured when start is accepted.
cin  input  1  carry-in; captured when start is accepted.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when a result completes.
sum  output  WIDTH  last completed sum; held until the next completion.
cout  output  1  carry-out of the last completed sum; held until the next completion.
sum_bit  output  1  current serial sum bit (full_adder Sum); meaningful only while busy.

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE. Outputs: busy=0, done=0, sum=0, cout=0. Operand shift registers, carry flip-flop and bit counter clear to 0. sum_bit is combinational and therefore 0.
- FSM states:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> SHIFT while bits remain.
  - SHIFT -> DONE after bit WIDTH-1 is processed.
  - DONE -> SHIFT if start=1 in DONE; DONE -> IDLE otherwise.
- Accept: start is accepted only in IDLE or DONE. On accept:
  - shreg_a <= a_in, shreg_b <= b_in;
  - carry_q <= cin, cnt <= 0, accumulator <= 0.
- start is ignored in SHIFT. Operand changes in SHIFT have no effect.
- SHIFT cycle, one per clock:
  - full_adder inputs: a=shreg_a[0], b=shreg_b[0], c=carry_q.
  - carry_q <= Carry.
  - Accumulator shifts right with Sum entering at bit WIDTH-1.
  - shreg_a and shreg_b shift right, zero-filled.
  - cnt <= cnt+1. cnt width is $clog2(WIDTH+1), minimum 1.
- Last bit (cnt==WIDTH-1):
  - the same edge loads sum <= final accumulator value, including this bit's Sum;
  - the same edge loads cout <= Carry;
  - FSM moves to DONE.
- busy=1 exactly in SHIFT. done=1 exactly in DONE, one cycle per completed operation.
- Latency: start accepted at edge N -> busy high after edges N..N+WIDTH-1 -> sum/cout updated and done high after edge N+WIDTH. Total WIDTH+1 cycles from start to done.
- Back-to-back: start high during DONE begins a new operation at that edge. done drops and busy rises on the next cycle. Throughput is one result per WIDTH+1 cycles.
- sum/cout hold the previous result during SHIFT and change only on the completing edge.
- Arithmetic: {cout,sum} = a_in + b_in + cin, modulo 2^(WIDTH+1). There is no overflow flag.
- Reset mid-operation: the operation is abandoned, no done pulse is produced, and all outputs go to reset values immediately.
- WIDTH=1: a single SHIFT cycle, then DONE.

Test Plan:
- Reset: assert rst_n=0 mid-simulation with clk running -> busy=0, done=0, sum=0x00, cout=0 immediately; no done pulse afterwards.
- Basic add, WIDTH=8: a_in=0x3C, b_in=0x42, cin=0, start pulse -> busy high 8 cycles; done single pulse on cycle 9 after start edge; sum=0x7E, cout=0. sum_bit sequence LSB first is 0,1,1,1,1,1,1,0.
- Full carry ripple: a_in=0xFF, b_in=0x01, cin=0 -> sum=0x00, cout=1. Then a_in=0x5A, b_in=0xA5, cin=1 -> sum=0x00, cout=1.
- start while busy: start pulse at cycle 3 of an operation with a_in=0x11 -> ignored; result remains the original operation's value; exactly one done pulse.
- Back-to-back: hold start=1 continuously with 0x01+0x01, then 0x80+0x80 on the DONE cycle:
  - first result is sum=0x02, cout=0;
  - next done pulse arrives 9 cycles later with sum=0x00, cout=1;
  - busy is never high in the same cycle as done.
- Exhaustive WIDTH=2 instance: all 32 combinations of a_in, b_in, cin -> {cout,sum} matches a_in+b_in+cin; done high exactly 3 cycles after each start.
